// File: rtl/mul_sequencer_pkg.sv
// Shared types and constants for the M-extension multiply issue controller.
// The cache record is sized by MUL_XLEN, so the controller's XLEN must match it.
package mul_sequencer_pkg;

    localparam int MUL_XLEN        = 32;
    localparam int MUL_TAG_W       = 5;
    localparam int MUL_CORE_CYCLES = 17;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mul_op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COMPUTE = 3'd1,
        DRAIN   = 3'd2,
        CORRECT = 3'd3,
        DONE    = 3'd4
    } mul_state_e;

    typedef enum logic [1:0] {
        CLS_SIGNED = 2'd0,
        CLS_SU     = 2'd1,
        CLS_U      = 2'd2
    } mul_cls_e;

    typedef struct packed {
        logic                valid;
        logic [MUL_XLEN-1:0] rs1;
        logic [MUL_XLEN-1:0] rs2;
        mul_cls_e            cls;
        logic [MUL_XLEN-1:0] hi;
        logic [MUL_XLEN-1:0] lo;
    } mul_cache_s;

    // MUL and MULH share the signed class: the core always produces the signed product.
    function automatic mul_cls_e op_class(input mul_op_e op);
        case (op)
            MULHSU:  return CLS_SU;
            MULHU:   return CLS_U;
            default: return CLS_SIGNED;
        endcase
    endfunction

endpackage

// File: rtl/mul_sequencer.sv
// Issue-side controller for the iterative signed Booth radix-4 multiplier core.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int XLEN        = MUL_XLEN,
    parameter int TAG_W       = MUL_TAG_W,
    parameter int CORE_CYCLES = MUL_CORE_CYCLES
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [XLEN-1:0]   req_rs1_i,
    input  logic [XLEN-1:0]   req_rs2_i,
    input  logic [TAG_W-1:0]  req_tag_i,
    input  logic              kill_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [XLEN-1:0]   res_data_o,
    output logic [TAG_W-1:0]  res_tag_o,
    output logic              core_clk_en_o,
    output logic [XLEN-1:0]   core_multiplier_o,
    output logic [XLEN-1:0]   core_multiplicand_o,
    input  logic [2*XLEN-1:0] core_result_i,
    input  logic              core_free_i,
    output logic              busy_o,
    output mul_state_e        dbg_state_o
);

    localparam int CNT_W = (CORE_CYCLES > 1) ? $clog2(CORE_CYCLES) : 1;

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mul_op_e          op_q, op_d;
    logic [XLEN-1:0]  rs1_q, rs1_d;
    logic [XLEN-1:0]  rs2_q, rs2_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    mul_cache_s       cache_q, cache_d;

    mul_op_e          req_op;
    logic             cache_hit;
    logic [XLEN-1:0]  hi_corr;

    assign req_op = mul_op_e'(req_op_i);

    // The low word does not depend on signedness, so MUL hits on any cached class.
    assign cache_hit = cache_q.valid
                    && (cache_q.rs1 == req_rs1_i)
                    && (cache_q.rs2 == req_rs2_i)
                    && ((req_op == MUL) || (cache_q.cls == op_class(req_op)));

    // Turns the core's signed high word into the mixed/unsigned high word.
    always_comb begin
        hi_corr = '0;
        case (op_q)
            MULHSU:  hi_corr = rs2_q[XLEN-1] ? rs1_q : '0;
            MULHU:   hi_corr = (rs1_q[XLEN-1] ? rs2_q : '0) + (rs2_q[XLEN-1] ? rs1_q : '0);
            default: hi_corr = '0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        tag_d         = tag_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        cache_d       = cache_q;
        req_ready_o   = 1'b0;
        res_valid_o   = 1'b0;
        core_clk_en_o = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_o = core_free_i & ~kill_i & ~rst_i;
                if (req_valid_i && req_ready_o) begin
                    op_d  = req_op;
                    rs1_d = req_rs1_i;
                    rs2_d = req_rs2_i;
                    tag_d = req_tag_i;
                    if (cache_hit) begin
                        hi_d    = cache_q.hi;
                        lo_d    = cache_q.lo;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_W'(CORE_CYCLES - 1);
                        state_d = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                core_clk_en_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d = kill_i ? IDLE : CORRECT;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = kill_i ? DRAIN : COMPUTE;
                end
            end
            // The core must be clocked back to its idle count before the next load.
            DRAIN: begin
                core_clk_en_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CORRECT: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else begin
                    hi_d          = core_result_i[2*XLEN-1:XLEN] + hi_corr;
                    lo_d          = core_result_i[XLEN-1:0];
                    cache_d.valid = 1'b1;
                    cache_d.rs1   = rs1_q;
                    cache_d.rs2   = rs2_q;
                    cache_d.cls   = op_class(op_q);
                    cache_d.hi    = core_result_i[2*XLEN-1:XLEN] + hi_corr;
                    cache_d.lo    = core_result_i[XLEN-1:0];
                    state_d       = DONE;
                end
            end
            DONE: begin
                res_valid_o = 1'b1;
                if (kill_i || res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= MUL;
            rs1_q   <= '0;
            rs2_q   <= '0;
            tag_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cache_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            tag_q   <= tag_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cache_q <= cache_d;
        end
    end

    assign res_data_o          = (state_q == DONE) ? ((op_q == MUL) ? lo_q : hi_q) : '0;
    assign res_tag_o           = (state_q == DONE) ? tag_q : '0;
    assign core_multiplier_o   = rs1_q;
    assign core_multiplicand_o = rs2_q;
    assign busy_o              = (state_q != IDLE);
    assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer with a behavioural 17-cycle multiplier core.
module tb_mul_sequencer;
  import mul_sequencer_pkg::*;

  localparam int XLEN = 32;
  localparam int TAG_W = 5;
  localparam int CORE_N = 17;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_op = 2'd0;
  logic [XLEN-1:0]   req_rs1 = '0;
  logic [XLEN-1:0]   req_rs2 = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic              kill = 1'b0;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [XLEN-1:0]   res_data;
  logic [TAG_W-1:0]  res_tag;
  logic              core_clk_en;
  logic [XLEN-1:0]   core_mplier;
  logic [XLEN-1:0]   core_mcand;
  logic [2*XLEN-1:0] core_result;
  logic              core_free;
  logic              busy;
  mul_state_e        dbg_state;

  mul_sequencer dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .req_valid_i         (req_valid),
    .req_ready_o         (req_ready),
    .req_op_i            (req_op),
    .req_rs1_i           (req_rs1),
    .req_rs2_i           (req_rs2),
    .req_tag_i           (req_tag),
    .kill_i              (kill),
    .res_valid_o         (res_valid),
    .res_ready_i         (res_ready),
    .res_data_o          (res_data),
    .res_tag_o           (res_tag),
    .core_clk_en_o       (core_clk_en),
    .core_multiplier_o   (core_mplier),
    .core_multiplicand_o (core_mcand),
    .core_result_i       (core_result),
    .core_free_i         (core_free),
    .busy_o              (busy),
    .dbg_state_o         (dbg_state)
  );

  // behavioural core: loads on the first enabled edge, final product after the 17th
  int unsigned    core_cnt;
  logic [XLEN-1:0] core_a, core_b;
  assign core_free = (core_cnt == 0);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_cnt <= 0;
      core_a <= '0;
      core_b <= '0;
      core_result <= '0;
    end else if (core_clk_en) begin
      if (core_cnt == 0) begin
        core_a <= core_mplier;
        core_b <= core_mcand;
        core_result <= '0;
        core_cnt <= 1;
      end else if (core_cnt == CORE_N - 1) begin
        core_result <= {{XLEN{core_a[XLEN-1]}}, core_a} * {{XLEN{core_b[XLEN-1]}}, core_b};
        core_cnt <= 0;
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [TAG_W+XLEN-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // reference: extend each operand per op, take the 64-bit product, pick the word
  function automatic logic [XLEN-1:0] model(input logic [1:0] op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic sa, sb;
    logic [63:0] x, y, p;
    sa = (op != 2'd3);
    sb = (op == 2'd0) || (op == 2'd1);
    x = {{32{sa & a[31]}}, a};
    y = {{32{sb & b[31]}}, b};
    p = x * y;
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // activity counters sampled on the falling edge
  int en_cnt = 0;
  int valid_cnt = 0;
  int early_ready_cnt = 0;
  always @(negedge clk) begin
    if (core_clk_en) en_cnt++;
    if (res_valid) valid_cnt++;
    if (req_ready && !core_free) early_ready_cnt++;
  end

  // scoreboard: pop on every accepted result
  always @(negedge clk) begin
    logic [TAG_W+XLEN-1:0] e;
    if (!rst && res_valid && res_ready && !kill) begin
      if (exp_q.size() == 0) begin
        check("res_unexpected_q_size", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("res_data", res_data, e[XLEN-1:0]);
        check("res_tag", res_tag, e[TAG_W+XLEN-1:XLEN]);
      end
    end
  end

  // driver tasks
  task automatic send(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [TAG_W-1:0] tag, input bit push);
    int n;
    req_valid = 1'b1;
    req_op = op;
    req_rs1 = a;
    req_rs2 = b;
    req_tag = tag;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (push) exp_q.push_back({tag, model(op, a, b)});
  endtask

  task automatic wait_result(input int exp_lat, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_lat >= 0) check(name, 64'(n), 64'(exp_lat));
    else if (!res_valid) check("result_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int en_base, v_base, r_base, n;
    logic [XLEN-1:0] a, b, hold_data;
    logic [TAG_W-1:0] hold_tag;
    logic [1:0] op;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_outputs", {busy, res_valid, core_clk_en, res_data, res_tag}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("idle_ready", req_ready, 1);

    // basic miss
    en_base = en_cnt;
    send(MUL, 32'd7, 32'hFFFFFFFD, 5'd5, 1);
    wait_result(18, "lat_mul_miss");
    check("en_cycles_mul", 64'(en_cnt - en_base), 64'd17);

    // MULHU then cache hit with MUL
    send(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 1);
    wait_result(18, "lat_mulhu");
    en_base = en_cnt;
    send(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 1);
    wait_result(0, "lat_hit_mul");
    check("en_cycles_hit", 64'(en_cnt - en_base), 64'd0);

    send(MULHSU, 32'hFFFFFFFF, 32'h80000000, 5'd11, 1);
    wait_result(18, "lat_mulhsu");
    send(MULH, 32'h80000000, 32'h80000000, 5'd12, 1);
    wait_result(18, "lat_mulh");
    send(MUL, 32'd123, 32'hFFFFFE38, 5'd13, 1);
    wait_result(18, "lat_mul2");
    send(MULH, 32'd123, 32'hFFFFFE38, 5'd14, 1);
    wait_result(0, "lat_hit_mulh");
    send(MULHU, 32'd123, 32'hFFFFFE38, 5'd15, 1);
    wait_result(18, "lat_class_miss");

    // kill during COMPUTE
    en_base = en_cnt;
    v_base = valid_cnt;
    r_base = early_ready_cnt;
    send(MUL, 32'd100, 32'd200, 5'd3, 0);
    repeat (5) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill_state", dbg_state, DRAIN);
    check("kill_ready", req_ready, 0);
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("kill_en_cycles", 64'(en_cnt - en_base), 64'd17);
    check("kill_no_valid", 64'(valid_cnt - v_base), 64'd0);
    check("kill_ready_early", 64'(early_ready_cnt - r_base), 64'd0);
    check("kill_ready_back", req_ready, 1);
    @(posedge clk);
    #1;
    send(MUL, 32'd3, 32'd4, 5'd4, 1);
    wait_result(18, "lat_after_kill");
    send(MUL, 32'd100, 32'd200, 5'd6, 1);
    wait_result(18, "lat_killed_not_cached");

    // backpressure in DONE
    res_ready = 1'b0;
    send(MULHU, 32'hDEADBEEF, 32'h12345678, 5'd7, 1);
    wait_result(18, "lat_stall");
    hold_data = model(MULHU, 32'hDEADBEEF, 32'h12345678);
    hold_tag = 5'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_data", res_data, hold_data);
      check("stall_tag", res_tag, hold_tag);
      check("stall_ready", {res_valid, req_ready}, 2'b10);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;

    // kill together with res_ready drops the result and keeps the cache
    res_ready = 1'b0;
    send(MUL, 32'd5, 32'd6, 5'd11, 0);
    wait_result(18, "lat_done_kill");
    kill = 1'b1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("done_kill_dropped", {res_valid, busy}, 2'b00);
    send(MULH, 32'd5, 32'd6, 5'd12, 1);
    wait_result(0, "lat_hit_after_kill");

    // random op followed by a MUL on the same operands (always a hit)
    for (int i = 0; i < 6; i++) begin
      op = 2'($urandom_range(1, 3));
      a = $urandom;
      b = $urandom;
      send(op, a, b, 5'($urandom_range(0, 31)), 1);
      wait_result(-1, "rand");
      send(MUL, a, b, 5'($urandom_range(0, 31)), 1);
      wait_result(0, "lat_rand_hit");
    end

    // asynchronous reset mid-COMPUTE
    send(MUL, 32'd9, 32'd9, 5'd1, 0);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_outputs", {busy, core_clk_en, res_valid, req_ready, core_mplier, core_mcand, res_data}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(MUL, 32'd2, 32'd2, 5'd2, 1);
    wait_result(18, "lat_after_reset");

    repeat (2) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
